dcache_sram_nway: RTL and testbench

//   Parametrised N-way set-associative data-cache storage array with true-LRU replacement, per-line valid/dirty state,

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_lru_nway.sv | 58 +++++
 rtl/dcache_sram_nway.sv | 197 +++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the N-way data-cache storage array: flush walker states and the per-line state view.
package dcache_pkg;

    // Upper bound on the tag width; narrower tags are zero-extended into the line view.
    localparam int TAG_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WB,
        DONE
    } flush_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_state_t;

endpackage

// File: rtl/dcache_lru_nway.sv
// True-LRU age tracking for every set; age 0 is most recent and age WAYS-1 is the replacement candidate.
module dcache_lru_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             acc_i,
    input  logic [IDX_W-1:0] acc_set_i,
    input  logic [WAY_W-1:0] acc_way_i,
    input  logic [IDX_W-1:0] rd_set_i,
    output logic [WAY_W-1:0] victim_way_o
);

    logic [WAYS-1:0][WAY_W-1:0] age_q [SETS];
    logic [WAYS-1:0][WAY_W-1:0] age_d [SETS];
    logic [WAY_W-1:0]           old_age;

    assign old_age = age_q[acc_set_i][acc_way_i];

    // Only ways younger than the touched one age by one, so each set stays a permutation.
    always_comb begin
        age_d = age_q;
        if (acc_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == acc_way_i) begin
                    age_d[acc_set_i][w] = '0;
                end else if (age_q[acc_set_i][w] < old_age) begin
                    age_d[acc_set_i][w] = age_q[acc_set_i][w] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        victim_way_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[rd_set_i][w] == WAY_W'(WAYS - 1)) begin
                victim_way_o = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true-LRU replacement, byte-masked write hits
// and a dirty-line flush walker that offers each dirty line for writeback.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    parameter int IDX_W  = $clog2(SETS),
    parameter int WAY_W  = $clog2(WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic                fill_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [LINE_W-1:0]   wdata_i,
    input  logic [LINE_W/8-1:0] wmask_i,
    input  logic                fill_dirty_i,
    output logic                hit_o,
    output logic [WAY_W-1:0]    hit_way_o,
    output logic [LINE_W-1:0]   rdata_o,
    output logic [WAY_W-1:0]    victim_way_o,
    output logic                victim_valid_o,
    output logic                victim_dirty_o,
    output logic [TAG_W-1:0]    victim_tag_o,
    output logic [LINE_W-1:0]   victim_data_o,
    input  logic                flush_i,
    output logic                flush_busy_o,
    output logic                flush_done_o,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [IDX_W-1:0]    wb_idx_o,
    output logic [TAG_W-1:0]    wb_tag_o,
    output logic [LINE_W-1:0]   wb_data_o
);

    localparam int LINES = SETS * WAYS;
    localparam int BYTES = LINE_W / 8;
    localparam int PTR_W = IDX_W + WAY_W;

    // Line address is {set, way}; the flush pointer uses the same layout so it walks way-minor.
    logic [LINE_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];

    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    flush_state_e      state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    line_state_t       line_v [WAYS];
    line_state_t       victim_line;
    logic [WAYS-1:0]   match;
    logic              busy, hit_raw, acc_ok, do_fill, do_write, lru_acc, last_ptr;
    logic [WAY_W-1:0]  hit_way, victim_way, lru_victim, lru_way;
    logic [PTR_W-1:0]  hit_addr, vic_addr;
    logic [LINE_W-1:0] hit_data, merged;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        localparam logic [WAY_W-1:0] WAY_ID = WAY_W'(gi);
        assign line_v[gi] = line_state_t'{
            valid: valid_q[{idx_i, WAY_ID}],
            dirty: dirty_q[{idx_i, WAY_ID}],
            tag:   TAG_MAX_W'(tag_mem[{idx_i, WAY_ID}])
        };
        assign match[gi] = line_v[gi].valid && (line_v[gi].tag == TAG_MAX_W'(tag_i));
    end

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WAY_W'(w);
        end
    end

    // An empty way is always preferred over evicting the LRU line.
    always_comb begin
        victim_way = lru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!line_v[w].valid) victim_way = WAY_W'(w);
        end
    end

    assign busy        = (state_q != IDLE);
    assign hit_raw     = |match;
    assign hit_addr    = {idx_i, hit_way};
    assign vic_addr    = {idx_i, victim_way};
    assign hit_data    = data_mem[hit_addr];
    assign victim_line = line_v[victim_way];

    assign acc_ok   = req_i && !busy;
    assign do_fill  = acc_ok && fill_i;
    assign do_write = acc_ok && we_i && !fill_i && hit_raw;
    assign lru_acc  = do_fill || (acc_ok && hit_raw);
    assign lru_way  = do_fill ? victim_way : hit_way;
    assign last_ptr = &ptr_q;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
        assign merged[gi*8 +: 8] = wmask_i[gi] ? wdata_i[gi*8 +: 8] : hit_data[gi*8 +: 8];
    end

    dcache_lru_nway #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .acc_i        (lru_acc),
        .acc_set_i    (idx_i),
        .acc_way_i    (lru_way),
        .rd_set_i     (idx_i),
        .victim_way_o (lru_victim)
    );

    always_ff @(posedge clk_i) begin
        if (do_fill) begin
            data_mem[vic_addr] <= wdata_i;
            tag_mem[vic_addr]  <= tag_i;
        end else if (do_write) begin
            data_mem[hit_addr] <= merged;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (do_fill) begin
            valid_d[vic_addr] = 1'b1;
            dirty_d[vic_addr] = fill_dirty_i;
        end
        if (do_write) begin
            dirty_d[hit_addr] = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                end
            end
            SCAN: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                    state_d = WB;
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = last_ptr ? DONE : SCAN;
                end
            end
            WB: begin
                if (wb_ready_i) begin
                    dirty_d[ptr_q] = 1'b0;
                    ptr_d          = ptr_q + PTR_W'(1);
                    state_d        = last_ptr ? DONE : SCAN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data arrays are never cleared, so every read-out is gated to keep outputs defined.
    assign hit_o          = hit_raw && !busy;
    assign hit_way_o      = hit_o ? hit_way : '0;
    assign rdata_o        = hit_o ? hit_data : '0;
    assign victim_way_o   = victim_way;
    assign victim_valid_o = victim_line.valid;
    assign victim_dirty_o = victim_line.valid && victim_line.dirty;
    assign victim_tag_o   = victim_line.valid ? victim_line.tag[TAG_W-1:0] : '0;
    assign victim_data_o  = victim_line.valid ? data_mem[vic_addr] : '0;

    assign flush_busy_o = busy;
    assign flush_done_o = (state_q == DONE);
    assign wb_valid_o   = (state_q == WB);
    assign wb_idx_o     = wb_valid_o ? ptr_q[PTR_W-1 -: IDX_W] : '0;
    assign wb_tag_o     = wb_valid_o ? tag_mem[ptr_q] : '0;
    assign wb_data_o    = wb_valid_o ? data_mem[ptr_q] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Bench for dcache_sram_nway: directed vector table, flush/reset sequences and randomized traffic
// compared against a recency-list cache model.
module tb_dcache_sram_nway;

    logic         clk;
    logic         rst_n;
    logic         req_i, we_i, fill_i, fill_dirty_i, flush_i, wb_ready_i;
    logic [3:0]   idx_i;
    logic [22:0]  tag_i;
    logic [255:0] wdata_i;
    logic [31:0]  wmask_i;
    logic         hit_o, victim_valid_o, victim_dirty_o;
    logic         flush_busy_o, flush_done_o, wb_valid_o;
    logic [1:0]   hit_way_o, victim_way_o;
    logic [255:0] rdata_o, victim_data_o, wb_data_o;
    logic [22:0]  victim_tag_o, wb_tag_o;
    logic [3:0]   wb_idx_o;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int wb_cnt   = 0;

    dcache_sram_nway dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .req_i          (req_i),
        .we_i           (we_i),
        .fill_i         (fill_i),
        .idx_i          (idx_i),
        .tag_i          (tag_i),
        .wdata_i        (wdata_i),
        .wmask_i        (wmask_i),
        .fill_dirty_i   (fill_dirty_i),
        .hit_o          (hit_o),
        .hit_way_o      (hit_way_o),
        .rdata_o        (rdata_o),
        .victim_way_o   (victim_way_o),
        .victim_valid_o (victim_valid_o),
        .victim_dirty_o (victim_dirty_o),
        .victim_tag_o   (victim_tag_o),
        .victim_data_o  (victim_data_o),
        .flush_i        (flush_i),
        .flush_busy_o   (flush_busy_o),
        .flush_done_o   (flush_done_o),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_idx_o       (wb_idx_o),
        .wb_tag_o       (wb_tag_o),
        .wb_data_o      (wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (flush_done_o) done_cnt++;
        if (wb_valid_o) wb_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // Reference model: per-set line state plus a recency list (front = most recent).
    logic         m_valid [16][4];
    logic         m_dirty [16][4];
    logic [22:0]  m_tag   [16][4];
    logic [255:0] m_data  [16][4];
    int           m_order [16][$];

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_order[s] = {};
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s].push_back(w);
            end
        end
    endtask

    function automatic int m_hit_way(input int s, input int t);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == 23'(t)) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < 4; w++)
            if (!m_valid[s][w]) return w;
        return m_order[s][$];
    endfunction

    task automatic m_touch(input int s, input int w);
        for (int i = 0; i < m_order[s].size(); i++) begin
            if (m_order[s][i] == w) begin
                m_order[s].delete(i);
                break;
            end
        end
        m_order[s].push_front(w);
    endtask

    function automatic logic [255:0] wd_of(input logic [22:0] t);
        return {8{9'd0, t}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one access at the falling edge, compare lookup/victim outputs, then advance the model.
    task automatic step(input logic rq, input logic we, input logic fl, input int idx, input int tag,
                        input logic [255:0] wd, input logic [31:0] wm, input logic fd);
        int hw, vw;
        @(negedge clk);
        req_i = rq; we_i = we; fill_i = fl; idx_i = 4'(idx); tag_i = 23'(tag);
        wdata_i = wd; wmask_i = wm; fill_dirty_i = fd;
        #1;
        hw = m_hit_way(idx, tag);
        vw = m_victim(idx);
        chk("hit", 256'(hit_o), 256'(hw >= 0));
        chk("hit_way", 256'(hit_way_o), (hw >= 0) ? 256'(hw) : 256'd0);
        chk("rdata", rdata_o, (hw >= 0) ? m_data[idx][hw] : 256'd0);
        chk("victim_way", 256'(victim_way_o), 256'(vw));
        chk("victim_valid", 256'(victim_valid_o), 256'(m_valid[idx][vw]));
        chk("victim_dirty", 256'(victim_dirty_o), 256'(m_valid[idx][vw] && m_dirty[idx][vw]));
        chk("victim_tag", 256'(victim_tag_o), m_valid[idx][vw] ? 256'(m_tag[idx][vw]) : 256'd0);
        chk("victim_data", victim_data_o, m_valid[idx][vw] ? m_data[idx][vw] : 256'd0);
        if (rq) begin
            if (fl) begin
                m_valid[idx][vw] = 1'b1;
                m_dirty[idx][vw] = fd;
                m_tag[idx][vw]   = 23'(tag);
                m_data[idx][vw]  = wd;
                m_touch(idx, vw);
            end else if (hw >= 0) begin
                if (we) begin
                    for (int b = 0; b < 32; b++)
                        if (wm[b]) m_data[idx][hw][b*8 +: 8] = wd[b*8 +: 8];
                    m_dirty[idx][hw] = 1'b1;
                end
                m_touch(idx, hw);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 256'd0, 32'd0, 1'b0);
    endtask

    // which=0: wait for wb_valid_o high; which=1: wait for flush_busy_o low.
    task automatic wait_sig(input int which, input string nm);
        int n = 0;
        while (!((which == 0) ? wb_valid_o : !flush_busy_o) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, 256'(n < 200), 256'd1);
    endtask

    typedef struct {
        int op;      // 0 read, 1 write, 2 fill
        int idx;
        int tag;
        int e_hit;
        int e_hway;
        int e_vway;
        int e_vvalid;
        int e_vtag;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{2, 3, 'h10, 0, 0, 0, 0, 0};
        vecs[1]  = '{2, 3, 'h11, 0, 0, 1, 0, 0};
        vecs[2]  = '{2, 3, 'h12, 0, 0, 2, 0, 0};
        vecs[3]  = '{2, 3, 'h13, 0, 0, 3, 0, 0};
        vecs[4]  = '{2, 3, 'h14, 0, 0, 0, 1, 'h10};
        vecs[5]  = '{0, 3, 'h10, 0, 0, 1, 1, 'h11};
        vecs[6]  = '{2, 4, 'h10, 0, 0, 0, 0, 0};
        vecs[7]  = '{2, 4, 'h11, 0, 0, 1, 0, 0};
        vecs[8]  = '{2, 4, 'h12, 0, 0, 2, 0, 0};
        vecs[9]  = '{2, 4, 'h13, 0, 0, 3, 0, 0};
        vecs[10] = '{0, 4, 'h10, 1, 0, 0, 1, 'h10};
        vecs[11] = '{2, 4, 'h20, 0, 0, 1, 1, 'h11};
        vecs[12] = '{0, 4, 'h20, 1, 1, 2, 1, 'h12};
        vecs[13] = '{1, 5, 'h99, 0, 0, 0, 0, 0};
        vecs[14] = '{2, 5, 'h30, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 3, 'h77, 0, 0, 1, 1, 'h11};
        vecs[16] = '{0, 3, 'h11, 1, 1, 1, 1, 'h11};

        req_i = 0; we_i = 0; fill_i = 0; idx_i = 0; tag_i = 0; wdata_i = 0; wmask_i = 0;
        fill_dirty_i = 0; flush_i = 0; wb_ready_i = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst hit", 256'(hit_o), 256'd0);
        chk("rst rdata", rdata_o, 256'd0);
        chk("rst victim_way", 256'(victim_way_o), 256'd0);
        chk("rst victim_valid", 256'(victim_valid_o), 256'd0);
        chk("rst victim_dirty", 256'(victim_dirty_o), 256'd0);
        chk("rst busy", 256'(flush_busy_o), 256'd0);
        chk("rst done", 256'(flush_done_o), 256'd0);
        chk("rst wb_valid", 256'(wb_valid_o), 256'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(1'b1, vecs[i].op == 1, vecs[i].op == 2, vecs[i].idx, vecs[i].tag,
                 (vecs[i].op == 2) ? wd_of(23'(vecs[i].tag)) : {256{1'b1}},
                 (vecs[i].op == 1) ? 32'hFFFF_FFFF : 32'd0, 1'b0);
            chk($sformatf("v%0d hit", i), 256'(hit_o), 256'(vecs[i].e_hit));
            chk($sformatf("v%0d hit_way", i), 256'(hit_way_o), 256'(vecs[i].e_hway));
            chk($sformatf("v%0d victim_way", i), 256'(victim_way_o), 256'(vecs[i].e_vway));
            chk($sformatf("v%0d victim_valid", i), 256'(victim_valid_o), 256'(vecs[i].e_vvalid));
            chk($sformatf("v%0d victim_tag", i), 256'(victim_tag_o), 256'(vecs[i].e_vtag));
        end

        // Byte-masked write hit, then age the line into the victim slot.
        step(1'b1, 1'b0, 1'b1, 6, 'h40, 256'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 6, 'h40, {256{1'b1}}, 32'h0000_000F, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6, 'h40, 256'd0, 32'd0, 1'b0);
        chk("wr merged rdata", rdata_o, 256'hFFFF_FFFF);
        step(1'b1, 1'b0, 1'b1, 6, 'h41, wd_of(23'h41), 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 6, 'h42, wd_of(23'h42), 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 6, 'h43, wd_of(23'h43), 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 6, 0, 256'd0, 32'd0, 1'b0);
        chk("wr victim_way", 256'(victim_way_o), 256'd0);
        chk("wr victim_dirty", 256'(victim_dirty_o), 256'd1);
        chk("wr victim_data", victim_data_o, 256'hFFFF_FFFF);

        // Flush with dirty lines only at (0,2) and (15,3).
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, 0, 'h100, wd_of(23'h100), 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 0, 'h101, wd_of(23'h101), 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 0, 'h102, wd_of(23'h102), 32'd0, 1'b1);
        for (int t = 0; t < 4; t++)
            step(1'b1, 1'b0, 1'b1, 15, 'h200 + t, wd_of(23'('h200 + t)), 32'd0, t == 3);
        idle();
        done_cnt = 0;
        wb_cnt   = 0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush busy", 256'(flush_busy_o), 256'd1);
        wait_sig(0, "wb1 offered");
        req_i = 1'b1; fill_i = 1'b1; idx_i = 4'd0; tag_i = 23'h100;
        for (int c = 0; c < 5; c++) begin
            chk("wb1 valid", 256'(wb_valid_o), 256'd1);
            chk("wb1 idx", 256'(wb_idx_o), 256'd0);
            chk("wb1 tag", 256'(wb_tag_o), 256'h102);
            chk("wb1 data", wb_data_o, wd_of(23'h102));
            chk("busy hit blocked", 256'(hit_o), 256'd0);
            @(negedge clk);
            #1;
        end
        req_i = 1'b0; fill_i = 1'b0;
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        #1;
        wait_sig(0, "wb2 offered");
        chk("wb2 idx", 256'(wb_idx_o), 256'd15);
        chk("wb2 tag", 256'(wb_tag_o), 256'h203);
        chk("wb2 data", wb_data_o, wd_of(23'h203));
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        #1;
        wait_sig(1, "flush1 ends");
        chk("flush1 done pulses", 256'(done_cnt), 256'd1);
        chk("flush1 wb cycles", 256'(wb_cnt), 256'd7);
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) m_dirty[s][w] = 1'b0;

        idle();
        done_cnt = 0;
        wb_cnt   = 0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        wait_sig(1, "flush2 ends");
        chk("flush2 wb cycles", 256'(wb_cnt), 256'd0);
        chk("flush2 done pulses", 256'(done_cnt), 256'd1);
        step(1'b1, 1'b0, 1'b0, 0, 'h100, 256'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 'h102, 256'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 15, 'h203, 256'd0, 32'd0, 1'b0);

        // Reset while a writeback is pending.
        step(1'b1, 1'b0, 1'b1, 7, 'h300, wd_of(23'h300), 32'd0, 1'b1);
        idle();
        done_cnt = 0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        wait_sig(0, "wb3 offered");
        rst_n = 1'b0;
        #1;
        chk("rst mid-WB busy", 256'(flush_busy_o), 256'd0);
        chk("rst mid-WB wb_valid", 256'(wb_valid_o), 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        #1;
        chk("rst mid-WB done pulses", 256'(done_cnt), 256'd0);
        chk("rst mid-WB idle", 256'(flush_busy_o), 256'd0);

        for (int r = 0; r < 300; r++) begin
            int op;
            op = int'($urandom_range(0, 9));
            step($urandom_range(0, 7) != 0, op >= 4 && op <= 7, op >= 7,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
